// File: rtl/bcd_counter_2digit_pkg.sv
// Shared types and constants for the two-digit BCD counter.
package bcd_counter_2digit_pkg;

  typedef logic [3:0] bcdDigit_t;

  localparam bcdDigit_t DIGIT_MAX = 4'd9;
  localparam bcdDigit_t DIGIT_MIN = 4'd0;

  // A nibble outside 0..9 has no decimal meaning downstream, so it becomes 0.
  function automatic bcdDigit_t sanitizeDigit(input logic [3:0] value);
    return (value > DIGIT_MAX) ? DIGIT_MIN : bcdDigit_t'(value);
  endfunction

endpackage

// File: rtl/bcd_counter_2digit_if.sv
// Control and digit bus of the two-digit BCD counter.
interface bcd_counter_2digit_if;
  import bcd_counter_2digit_pkg::*;

  logic      i_en;
  logic      i_up;
  logic      i_load;
  bcdDigit_t i_load_d0;
  bcdDigit_t i_load_d1;
  logic      i_step;
  bcdDigit_t o_digit0;
  bcdDigit_t o_digit1;
  logic      o_wrap;

  modport master (
    output i_en, i_up, i_load, i_load_d0, i_load_d1, i_step,
    input  o_digit0, o_digit1, o_wrap
  );

  modport slave (
    input  i_en, i_up, i_load, i_load_d0, i_load_d1, i_step,
    output o_digit0, o_digit1, o_wrap
  );

endinterface

// File: rtl/bcd_counter_2digit_digit.sv
// One BCD decade: holds 0..9, steps up or down, and flags carry or borrow.
module bcd_digit
  import bcd_counter_2digit_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      i_load,
  input  bcdDigit_t i_loadValue,
  input  logic      i_inc,
  input  logic      i_dec,
  output bcdDigit_t o_value,
  output logic      o_carry,
  output logic      o_borrow
);

  bcdDigit_t r_value;

  assign o_value  = r_value;
  assign o_carry  = i_inc && (r_value == DIGIT_MAX);
  assign o_borrow = i_dec && (r_value == DIGIT_MIN);

  // Load has priority; otherwise step once, rolling over at the decade ends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_value <= DIGIT_MIN;
    end else if (i_load) begin
      r_value <= sanitizeDigit(i_loadValue);
    end else if (i_inc) begin
      r_value <= (r_value == DIGIT_MAX) ? DIGIT_MIN : r_value + 4'd1;
    end else if (i_dec) begin
      r_value <= (r_value == DIGIT_MIN) ? DIGIT_MAX : r_value - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_counter_2digit.sv
// Two-digit BCD up/down counter driven by a prescaled tick or a push button.
module bcd_counter_2digit
  import bcd_counter_2digit_pkg::*;
#(
  parameter int PRESCALE = 50_000_000
) (
  input logic clk,
  input logic reset_n,
  bcd_counter_2digit_if.slave bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_prescale;
  logic          r_stepSync1;
  logic          r_stepSync2;
  logic          r_stepPrev;
  logic          r_wrap;

  logic      w_tick;
  logic      w_stepRise;
  logic      w_countEvent;
  logic      w_inc;
  logic      w_dec;
  logic      w_unitsCarry;
  logic      w_unitsBorrow;
  logic      w_tensCarry;
  logic      w_tensBorrow;
  bcdDigit_t w_digit0;
  bcdDigit_t w_digit1;

  assign w_tick       = bus.i_en && (r_prescale == PRESCALE_LAST);
  assign w_stepRise   = r_stepSync2 && !r_stepPrev;
  assign w_countEvent = w_tick || w_stepRise;
  assign w_inc        = !bus.i_load && w_countEvent && bus.i_up;
  assign w_dec        = !bus.i_load && w_countEvent && !bus.i_up;

  // Time base: free-runs while enabled, holds otherwise, restarts on load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prescale <= '0;
    end else if (bus.i_load || w_tick) begin
      r_prescale <= '0;
    end else if (bus.i_en) begin
      r_prescale <= r_prescale + PW'(1);
    end
  end

  // Bring the button into the clock domain and remember it for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stepSync1 <= 1'b0;
      r_stepSync2 <= 1'b0;
      r_stepPrev  <= 1'b0;
    end else begin
      r_stepSync1 <= bus.i_step;
      r_stepSync2 <= r_stepSync1;
      r_stepPrev  <= r_stepSync2;
    end
  end

  bcd_digit u_units (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_load      (bus.i_load),
    .i_loadValue (bus.i_load_d0),
    .i_inc       (w_inc),
    .i_dec       (w_dec),
    .o_value     (w_digit0),
    .o_carry     (w_unitsCarry),
    .o_borrow    (w_unitsBorrow)
  );

  bcd_digit u_tens (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_load      (bus.i_load),
    .i_loadValue (bus.i_load_d1),
    .i_inc       (w_unitsCarry),
    .i_dec       (w_unitsBorrow),
    .o_value     (w_digit1),
    .o_carry     (w_tensCarry),
    .o_borrow    (w_tensBorrow)
  );

  // Wrap pulses for one cycle after the tens decade rolls over either way.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_tensCarry || w_tensBorrow;
    end
  end

  assign bus.o_digit0 = w_digit0;
  assign bus.o_digit1 = w_digit1;
  assign bus.o_wrap   = r_wrap;

endmodule

// File: tb/tb_bcd_counter_2digit.sv
// Directed bench for the two-digit BCD counter with a short prescale period.
module tb_bcd_counter_2digit;
  import bcd_counter_2digit_pkg::*;

  localparam int PRESCALE = 4;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  logic [8:0] observed;

  bcd_counter_2digit_if bus ();

  bcd_counter_2digit #(.PRESCALE(PRESCALE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Outputs packed as {wrap, tens, units} so expected values read as 9'h1_99 etc.
  always_comb observed = {bus.o_wrap, bus.o_digit1, bus.o_digit0};

  // Advance past the next rising edge and settle.
  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic loadValue(input logic [3:0] d1, input logic [3:0] d0);
    bus.i_load    = 1'b1;
    bus.i_load_d1 = d1;
    bus.i_load_d0 = d0;
    stepClk();
    bus.i_load = 1'b0;
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    bus.i_en     = 1'b0;
    bus.i_up     = 1'b1;
    bus.i_load   = 1'b0;
    bus.i_load_d0 = '0;
    bus.i_load_d1 = '0;
    bus.i_step   = 1'b0;
    #23;
    checks++;
    if (observed !== 9'h000) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h expected %h", observed, 9'h000);
    end
    @(negedge clk);
    reset_n = 1'b1;
    stepClk();
  endtask

  task automatic test_prescale_count();
    bus.i_en = 1'b1;
    bus.i_up = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      stepClk();
      checks++;
      if (observed !== {1'b0, 4'd0, 4'(e / 4)}) begin
        errors++;
        $display("[TB] FAIL prescale_edge%0d: got %h expected %h", e, observed, {1'b0, 4'd0, 4'(e / 4)});
      end
    end
    bus.i_en = 1'b0;
  endtask

  task automatic test_wrap_up_step();
    loadValue(4'd9, 4'd9);
    checks++;
    if (observed !== 9'h099) begin
      errors++;
      $display("[TB] FAIL load_99: got %h expected %h", observed, 9'h099);
    end
    bus.i_up   = 1'b1;
    bus.i_step = 1'b1;
    stepClk();
    stepClk();
    checks++;
    if (observed !== 9'h099) begin
      errors++;
      $display("[TB] FAIL step_sync_delay: got %h expected %h", observed, 9'h099);
    end
    stepClk();
    checks++;
    if (observed !== 9'h100) begin
      errors++;
      $display("[TB] FAIL wrap_up: got %h expected %h", observed, 9'h100);
    end
    bus.i_step = 1'b0;
    stepClk();
    checks++;
    if (observed !== 9'h000) begin
      errors++;
      $display("[TB] FAIL wrap_up_one_cycle: got %h expected %h", observed, 9'h000);
    end
    repeat (3) stepClk();
  endtask

  task automatic test_wrap_down_tick();
    loadValue(4'd0, 4'd0);
    bus.i_up = 1'b0;
    bus.i_en = 1'b1;
    repeat (3) stepClk();
    checks++;
    if (observed !== 9'h000) begin
      errors++;
      $display("[TB] FAIL down_before_tick: got %h expected %h", observed, 9'h000);
    end
    stepClk();
    checks++;
    if (observed !== 9'h199) begin
      errors++;
      $display("[TB] FAIL wrap_down: got %h expected %h", observed, 9'h199);
    end
    stepClk();
    checks++;
    if (observed !== 9'h099) begin
      errors++;
      $display("[TB] FAIL wrap_down_one_cycle: got %h expected %h", observed, 9'h099);
    end
    repeat (3) stepClk();
    checks++;
    if (observed !== 9'h098) begin
      errors++;
      $display("[TB] FAIL down_98: got %h expected %h", observed, 9'h098);
    end
    bus.i_en = 1'b0;
    bus.i_up = 1'b1;
  endtask

  task automatic test_load_sanitize();
    loadValue(4'd3, 4'hC);
    checks++;
    if (observed !== 9'h030) begin
      errors++;
      $display("[TB] FAIL load_units_invalid: got %h expected %h", observed, 9'h030);
    end
    loadValue(4'hA, 4'd5);
    checks++;
    if (observed !== 9'h005) begin
      errors++;
      $display("[TB] FAIL load_tens_invalid: got %h expected %h", observed, 9'h005);
    end
  endtask

  task automatic test_load_priority();
    bus.i_en = 1'b1;
    bus.i_up = 1'b1;
    repeat (3) stepClk();
    loadValue(4'd4, 4'd2);
    checks++;
    if (observed !== 9'h042) begin
      errors++;
      $display("[TB] FAIL load_beats_tick: got %h expected %h", observed, 9'h042);
    end
    repeat (4) stepClk();
    checks++;
    if (observed !== 9'h043) begin
      errors++;
      $display("[TB] FAIL after_collision_tick: got %h expected %h", observed, 9'h043);
    end
    repeat (2) stepClk();
    loadValue(4'd1, 4'd7);
    repeat (3) stepClk();
    checks++;
    if (observed !== 9'h017) begin
      errors++;
      $display("[TB] FAIL load_clears_prescaler: got %h expected %h", observed, 9'h017);
    end
    stepClk();
    checks++;
    if (observed !== 9'h018) begin
      errors++;
      $display("[TB] FAIL tick_after_load: got %h expected %h", observed, 9'h018);
    end
    bus.i_en = 1'b0;
  endtask

  task automatic test_step_hold();
    loadValue(4'd0, 4'd5);
    bus.i_step = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      stepClk();
      checks++;
      if (observed !== ((e >= 3) ? 9'h006 : 9'h005)) begin
        errors++;
        $display("[TB] FAIL step_hold_edge%0d: got %h expected %h", e, observed, (e >= 3) ? 9'h006 : 9'h005);
      end
    end
    bus.i_step = 1'b0;
    repeat (3) stepClk();
  endtask

  task automatic test_step_tick_coincide();
    loadValue(4'd0, 4'd5);
    bus.i_en = 1'b1;
    stepClk();
    bus.i_step = 1'b1;
    repeat (3) stepClk();
    checks++;
    if (observed !== 9'h006) begin
      errors++;
      $display("[TB] FAIL step_tick_single: got %h expected %h", observed, 9'h006);
    end
    repeat (4) stepClk();
    checks++;
    if (observed !== 9'h007) begin
      errors++;
      $display("[TB] FAIL after_coincide: got %h expected %h", observed, 9'h007);
    end
    bus.i_en   = 1'b0;
    bus.i_step = 1'b0;
    repeat (3) stepClk();
  endtask

  task automatic test_async_reset();
    loadValue(4'd5, 4'd7);
    bus.i_en = 1'b1;
    stepClk();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (observed !== 9'h000) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h expected %h", observed, 9'h000);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) stepClk();
    checks++;
    if (observed !== 9'h000) begin
      errors++;
      $display("[TB] FAIL post_reset_hold: got %h expected %h", observed, 9'h000);
    end
    stepClk();
    checks++;
    if (observed !== 9'h001) begin
      errors++;
      $display("[TB] FAIL post_reset_count: got %h expected %h", observed, 9'h001);
    end
    bus.i_en = 1'b0;
  endtask

  // Run every scenario in order, then report.
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_prescale_count();
    test_wrap_up_step();
    test_wrap_down_tick();
    test_load_sanitize();
    test_load_priority();
    test_step_hold();
    test_step_tick_coincide();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
